seven_segment_scanner: RTL and testbench

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_scanner_pkg.sv | 9 +
 rtl/seven_segment_scanner_prescaler.sv | 23 ++
 rtl/seven_segment_scanner.sv | 63 ++++++
 tb/tb_seven_segment_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_scanner_pkg.sv
// seven_segment_scanner_pkg: shared constants, index type and anode helper for the display scanner
package seven_segment_scanner_pkg;
   localparam int NUM_DIGITS = 4;
   localparam logic [3:0] AN_ALL_OFF = 4'b1111;
   typedef logic [1:0] digit_idx_t;
   function automatic logic [3:0] an_select(digit_idx_t i);
      return ~(4'b0001 << i);
   endfunction
endpackage

// File: rtl/seven_segment_scanner_prescaler.sv
// scan_prescaler: digit-slot counter producing the slot tick and the leading dead-time window
module scan_prescaler #(
   parameter int TICK_DIV = 100000,
   parameter int DEAD_CYCLES = 4,
   localparam int CW = $clog2(TICK_DIV)
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick,
   output logic dead
);
   logic [CW-1:0] count;
   // slot counter, frozen while scanning is disabled
   always_ff @(posedge clk)
      if (reset) count <= '0;
      else if (enable) count <= tick ? '0 : count + 1'b1;
   // last cycle of a slot and the anode-off window at its start
   always_comb begin
      tick = enable && count == CW'(TICK_DIV - 1);
      dead = int'(count) < DEAD_CYCLES;
   end
endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: four-digit multiplexed display scanner with frame-synchronous shadow loading
module seven_segment_scanner
   import seven_segment_scanner_pkg::*;
#(
   parameter int TICK_DIV = 100000,
   parameter int DEAD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank,
   output logic [3:0]  AN,
   output logic [3:0]  digit_data,
   output logic        digit_dp,
   output logic        frame_done
);
   logic        tick, dead, boundary, pend_valid;
   digit_idx_t  idx;
   logic [15:0] act_value, pend_value;
   logic [3:0]  act_dp, act_blank, pend_dp, pend_blank;
   scan_prescaler #(.TICK_DIV(TICK_DIV), .DEAD_CYCLES(DEAD_CYCLES)) u_prescaler (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .tick(tick),
      .dead(dead)
   );
   assign boundary = tick && idx == digit_idx_t'(NUM_DIGITS - 1);
   // digit index steps once per slot tick
   always_ff @(posedge clk)
      if (reset) idx <= '0;
      else if (tick) idx <= idx + 1'b1;
   // shadow loading: new content becomes visible only at a frame boundary so a frame is never torn
   always_ff @(posedge clk)
      if (reset) begin
         {act_value, act_dp, act_blank} <= '0;
         {pend_value, pend_dp, pend_blank} <= '0;
         pend_valid <= 1'b0;
      end else if (boundary) begin
         pend_valid <= 1'b0;
         if (load) {act_value, act_dp, act_blank} <= {value, dp_in, blank};
         else if (pend_valid) {act_value, act_dp, act_blank} <= {pend_value, pend_dp, pend_blank};
      end else if (load) begin
         {pend_value, pend_dp, pend_blank} <= {value, dp_in, blank};
         pend_valid <= 1'b1;
      end
   // registered outputs derived from this cycle's scan state and active content
   always_ff @(posedge clk)
      if (reset) begin
         AN <= AN_ALL_OFF;
         digit_data <= '0;
         digit_dp <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         AN <= (!enable || dead || act_blank[idx]) ? AN_ALL_OFF : an_select(idx);
         digit_data <= act_value[{idx, 2'b00} +: 4];
         digit_dp <= act_dp[idx];
         frame_done <= boundary;
      end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: scoreboard bench for the scanner with TICK_DIV=8, DEAD_CYCLES=2
module tb_seven_segment_scanner;
   import seven_segment_scanner_pkg::*;
   localparam int TD = 8;
   localparam int DC = 2;
   logic clk = 1'b0, reset = 1'b1, enable = 1'b0, load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0] dp_in = '0, blank = '0;
   logic [3:0] AN, digit_data;
   logic digit_dp, frame_done;
   int n_chk = 0, n_fail = 0;
   logic [9:0] sb[$];
   logic [9:0] exp_o;
   int m_cnt, m_idx, m_pv;
   logic [15:0] m_val, p_val;
   logic [3:0] m_dp, m_blk, p_dp, p_blk;

   always #5 clk = ~clk;

   seven_segment_scanner #(.TICK_DIV(TD), .DEAD_CYCLES(DC)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .load(load),
      .value(value),
      .dp_in(dp_in),
      .blank(blank),
      .AN(AN),
      .digit_data(digit_data),
      .digit_dp(digit_dp),
      .frame_done(frame_done)
   );

   function automatic logic [9:0] obs();
      return {AN, digit_data, digit_dp, frame_done};
   endfunction

   task automatic step();
      logic tk;
      logic [3:0] an;
      @(posedge clk);
      if (reset) begin
         sb.push_back({AN_ALL_OFF, 4'h0, 2'b00});
         m_cnt = 0; m_idx = 0; m_pv = 0;
         m_val = '0; m_dp = '0; m_blk = '0; p_val = '0; p_dp = '0; p_blk = '0;
      end else begin
         tk = enable && m_cnt == TD - 1;
         an = (!enable || m_cnt < DC || m_blk[m_idx]) ? AN_ALL_OFF : ~(4'b0001 << m_idx);
         sb.push_back({an, m_val[m_idx*4 +: 4], m_dp[m_idx], tk && m_idx == 3});
         if (tk && m_idx == 3) begin
            if (load) begin m_val = value; m_dp = dp_in; m_blk = blank; end
            else if (m_pv != 0) begin m_val = p_val; m_dp = p_dp; m_blk = p_blk; end
            m_pv = 0;
         end else if (load) begin
            p_val = value; p_dp = dp_in; p_blk = blank; m_pv = 1;
         end
         if (enable) m_cnt = tk ? 0 : m_cnt + 1;
         if (tk) m_idx = (m_idx + 1) % 4;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      exp_o = sb.pop_front(); n_chk++;
      if (obs() !== exp_o) begin n_fail++; $display("FAIL reset_sb: got %h want %h", obs(), exp_o); end
      n_chk++;
      if (obs() !== 10'h3C0) begin n_fail++; $display("FAIL reset_const: got %h want 3c0", obs()); end
      reset = 1'b0;
      enable = 1'b1;
   endtask

   task automatic test_scan();
      logic [3:0] want;
      for (int k = 0; k < 64; k++) begin
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o) begin n_fail++; $display("FAIL scan_sb: k=%0d got %h want %h", k, obs(), exp_o); end
         want = (k % 8 < 2) ? 4'hF : ~(4'b0001 << ((k / 8) % 4));
         n_chk++;
         if (AN !== want || digit_data !== 4'h0) begin
            n_fail++; $display("FAIL scan_an: k=%0d AN=%b data=%h want AN=%b data=0", k, AN, digit_data, want);
         end
      end
   endtask

   task automatic test_load();
      logic [15:0] v;
      v = 16'h1A2F;
      for (int k = 0; k < 10; k++) begin
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o) begin n_fail++; $display("FAIL load_pre: got %h want %h", obs(), exp_o); end
      end
      load = 1'b1; value = v; dp_in = 4'b0100; blank = 4'b0000;
      step();
      load = 1'b0;
      exp_o = sb.pop_front(); n_chk++;
      if (obs() !== exp_o) begin n_fail++; $display("FAIL load_strobe: got %h want %h", obs(), exp_o); end
      for (int g = 0; !(m_idx == 3 && m_cnt == TD - 1); g++) begin
         if (g > 64) begin n_chk++; n_fail++; $display("FAIL load_seek: boundary not reached"); break; end
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o || digit_data !== 4'h0) begin
            n_fail++; $display("FAIL load_hold: got %h want %h (data must stay 0)", obs(), exp_o);
         end
      end
      step();
      exp_o = sb.pop_front(); n_chk++;
      if (obs() !== exp_o) begin n_fail++; $display("FAIL load_boundary: got %h want %h", obs(), exp_o); end
      for (int k = 0; k < 32; k++) begin
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o) begin n_fail++; $display("FAIL load_sb: k=%0d got %h want %h", k, obs(), exp_o); end
         n_chk++;
         if (digit_data !== v[(k/8)*4 +: 4] || digit_dp !== (k / 8 == 2)) begin
            n_fail++; $display("FAIL load_digits: k=%0d data=%h dp=%b want data=%h dp=%b", k, digit_data, digit_dp, v[(k/8)*4 +: 4], k / 8 == 2);
         end
      end
   endtask

   task automatic test_overwrite();
      load = 1'b1; value = 16'h1111; dp_in = 4'b0000; blank = 4'b0000;
      step();
      load = 1'b0;
      exp_o = sb.pop_front(); n_chk++;
      if (obs() !== exp_o) begin n_fail++; $display("FAIL ovw_first: got %h want %h", obs(), exp_o); end
      step();
      exp_o = sb.pop_front(); n_chk++;
      if (obs() !== exp_o) begin n_fail++; $display("FAIL ovw_gap: got %h want %h", obs(), exp_o); end
      load = 1'b1; value = 16'h2222;
      step();
      load = 1'b0;
      exp_o = sb.pop_front(); n_chk++;
      if (obs() !== exp_o) begin n_fail++; $display("FAIL ovw_second: got %h want %h", obs(), exp_o); end
      for (int g = 0; !(m_idx == 3 && m_cnt == TD - 1); g++) begin
         if (g > 64) begin n_chk++; n_fail++; $display("FAIL ovw_seek: boundary not reached"); break; end
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o) begin n_fail++; $display("FAIL ovw_seek_sb: got %h want %h", obs(), exp_o); end
      end
      step();
      exp_o = sb.pop_front(); n_chk++;
      if (obs() !== exp_o) begin n_fail++; $display("FAIL ovw_boundary: got %h want %h", obs(), exp_o); end
      for (int k = 0; k < 31; k++) begin
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o || digit_data !== 4'h2) begin
            n_fail++; $display("FAIL ovw_frame2: k=%0d got %h want %h (data 2)", k, obs(), exp_o);
         end
      end
      load = 1'b1; value = 16'h3333;
      step();
      load = 1'b0;
      exp_o = sb.pop_front(); n_chk++;
      if (obs() !== exp_o) begin n_fail++; $display("FAIL ovw_tick_load: got %h want %h", obs(), exp_o); end
      for (int k = 0; k < 32; k++) begin
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o || digit_data !== 4'h3) begin
            n_fail++; $display("FAIL ovw_frame3: k=%0d got %h want %h (data 3)", k, obs(), exp_o);
         end
      end
   endtask

   task automatic test_blank();
      logic [3:0] want;
      load = 1'b1; value = 16'h4321; dp_in = 4'b0000; blank = 4'b1010;
      step();
      load = 1'b0; blank = 4'b0000;
      exp_o = sb.pop_front(); n_chk++;
      if (obs() !== exp_o) begin n_fail++; $display("FAIL blank_strobe: got %h want %h", obs(), exp_o); end
      for (int g = 0; !(m_idx == 3 && m_cnt == TD - 1); g++) begin
         if (g > 64) begin n_chk++; n_fail++; $display("FAIL blank_seek: boundary not reached"); break; end
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o) begin n_fail++; $display("FAIL blank_seek_sb: got %h want %h", obs(), exp_o); end
      end
      step();
      exp_o = sb.pop_front(); n_chk++;
      if (obs() !== exp_o) begin n_fail++; $display("FAIL blank_boundary: got %h want %h", obs(), exp_o); end
      for (int k = 0; k < 32; k++) begin
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o) begin n_fail++; $display("FAIL blank_sb: k=%0d got %h want %h", k, obs(), exp_o); end
         want = (k % 8 < 2 || (k / 8) % 2 == 1) ? 4'hF : ~(4'b0001 << (k / 8));
         n_chk++;
         if (AN !== want) begin n_fail++; $display("FAIL blank_an: k=%0d AN=%b want %b", k, AN, want); end
      end
   endtask

   task automatic test_enable_hold();
      for (int g = 0; m_cnt != 4; g++) begin
         if (g > 16) begin n_chk++; n_fail++; $display("FAIL hold_seek: mid-slot not reached"); break; end
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o) begin n_fail++; $display("FAIL hold_seek_sb: got %h want %h", obs(), exp_o); end
      end
      enable = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o || AN !== 4'hF || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL hold_off: k=%0d got %h want %h (AN 1111, no frame_done)", k, obs(), exp_o);
         end
      end
      enable = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o) begin n_fail++; $display("FAIL hold_resume: k=%0d got %h want %h", k, obs(), exp_o); end
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 10; k++) begin
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o) begin n_fail++; $display("FAIL rmid_pre: got %h want %h", obs(), exp_o); end
      end
      load = 1'b1; value = 16'h5555; dp_in = 4'b1111; blank = 4'b0000;
      step();
      load = 1'b0;
      exp_o = sb.pop_front(); n_chk++;
      if (obs() !== exp_o) begin n_fail++; $display("FAIL rmid_load: got %h want %h", obs(), exp_o); end
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o || obs() !== 10'h3C0) begin
            n_fail++; $display("FAIL rmid_reset: got %h want %h", obs(), exp_o);
         end
      end
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         exp_o = sb.pop_front(); n_chk++;
         if (obs() !== exp_o || digit_data !== 4'h0 || digit_dp !== 1'b0) begin
            n_fail++; $display("FAIL rmid_after: k=%0d got %h want %h (pending discarded)", k, obs(), exp_o);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_scan();
      test_load();
      test_overwrite();
      test_blank();
      test_enable_hold();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
